// File: rtl/sva_result_monitor.sv
// Result monitor for an assertion checker: run FSM, saturating result
// counters, evaluation index, first-fail capture and a fail-index log FIFO.
module sva_result_monitor #(
    parameter int CNT_WIDTH = 16,
    parameter int IDX_WIDTH = 16,
    parameter int LOG_DEPTH = 4
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 res_valid,
    input  logic                 res_succ,
    input  logic                 res_lazy,
    input  logic                 res_fail,
    output logic [CNT_WIDTH-1:0] succ_cnt,
    output logic [CNT_WIDTH-1:0] lazy_cnt,
    output logic [CNT_WIDTH-1:0] fail_cnt,
    output logic [IDX_WIDTH-1:0] eval_idx,
    output logic [IDX_WIDTH-1:0] first_fail_idx,
    output logic                 first_fail_vld,
    output logic [1:0]           status,
    output logic                 log_valid,
    output logic [IDX_WIDTH-1:0] log_data,
    input  logic                 log_ready,
    output logic                 log_ovf
);

    localparam int PW = $clog2(LOG_DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [IDX_WIDTH-1:0] IDX_ONE = IDX_WIDTH'(1);
    localparam logic [PW:0]          PTR_ONE = (PW + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_PASS = 2'd2,
        S_FAIL = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] succ_q, succ_d;
    logic [CNT_WIDTH-1:0] lazy_q, lazy_d;
    logic [CNT_WIDTH-1:0] fail_q, fail_d;
    logic [IDX_WIDTH-1:0] idx_q, idx_d;
    logic [IDX_WIDTH-1:0] ffi_q, ffi_d;
    logic                 ffv_q, ffv_d;
    logic                 ovf_q, ovf_d;
    logic [PW:0]          wr_q, wr_d;
    logic [PW:0]          rd_q, rd_d;
    logic [IDX_WIDTH-1:0] mem_q [LOG_DEPTH];

    logic start_acc;
    logic acc;
    logic empty;
    logic full;
    logic pop;
    logic push_req;
    logic wr_en;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(
        input logic [CNT_WIDTH-1:0] v,
        input logic                 en
    );
        return (en && (v != '1)) ? v + CNT_ONE : v;
    endfunction

    assign start_acc = start && (state_q != S_RUN);
    assign acc       = res_valid && (state_q == S_RUN);
    assign empty     = (wr_q == rd_q);
    assign full      = (wr_q[PW] != rd_q[PW]) &&
                       (wr_q[PW-1:0] == rd_q[PW-1:0]);
    assign pop       = !empty && log_ready;
    assign push_req  = acc && res_fail;
    // A pop in the same cycle frees the slot a full-FIFO push needs
    assign wr_en     = push_req && (!full || pop);

    always_comb begin
        state_d = state_q;
        succ_d  = succ_q;
        lazy_d  = lazy_q;
        fail_d  = fail_q;
        idx_d   = idx_q;
        ffi_d   = ffi_q;
        ffv_d   = ffv_q;
        ovf_d   = ovf_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        if (start_acc) begin
            state_d = S_RUN;
            succ_d  = '0;
            lazy_d  = '0;
            fail_d  = '0;
            idx_d   = '0;
            ffv_d   = 1'b0;
            ovf_d   = 1'b0;
            wr_d    = '0;
            rd_d    = '0;
        end else begin
            if (pop) begin
                rd_d = rd_q + PTR_ONE;
            end
            if (acc) begin
                idx_d  = idx_q + IDX_ONE;
                succ_d = sat_inc(succ_q, res_succ);
                lazy_d = sat_inc(lazy_q, res_lazy);
                fail_d = sat_inc(fail_q, res_fail);
                if (res_fail && !ffv_q) begin
                    ffi_d = idx_q;
                    ffv_d = 1'b1;
                end
                if (wr_en) begin
                    wr_d = wr_q + PTR_ONE;
                end else if (push_req) begin
                    ovf_d = 1'b1;
                end
            end
            // Verdict includes any fail accepted on the stop cycle itself
            if ((state_q == S_RUN) && stop) begin
                state_d = (fail_d != '0) ? S_FAIL : S_PASS;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= S_IDLE;
            succ_q  <= '0;
            lazy_q  <= '0;
            fail_q  <= '0;
            idx_q   <= '0;
            ffi_q   <= '0;
            ffv_q   <= 1'b0;
            ovf_q   <= 1'b0;
            wr_q    <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            succ_q  <= succ_d;
            lazy_q  <= lazy_d;
            fail_q  <= fail_d;
            idx_q   <= idx_d;
            ffi_q   <= ffi_d;
            ffv_q   <= ffv_d;
            ovf_q   <= ovf_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (wr_en) begin
            mem_q[wr_q[PW-1:0]] <= idx_q;
        end
    end

    assign succ_cnt       = succ_q;
    assign lazy_cnt       = lazy_q;
    assign fail_cnt       = fail_q;
    assign eval_idx       = idx_q;
    assign first_fail_idx = ffi_q;
    assign first_fail_vld = ffv_q;
    assign status         = state_q;
    assign log_valid      = !empty;
    assign log_data       = mem_q[rd_q[PW-1:0]];
    assign log_ovf        = ovf_q;

endmodule

// File: tb/tb_sva_result_monitor.sv
// Scoreboard bench for sva_result_monitor: two instances (wide and 3-bit
// counters/index) share stimulus and are checked against a queue-based model.
module tb_sva_result_monitor;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 0, stop = 0, rv = 0, rs = 0, rl = 0, rf = 0, rdy = 0;

    logic [15:0] a_succ, a_lazy, a_fail, a_idx, a_ffi, a_ld;
    logic        a_ffv, a_lv, a_ovf;
    logic [1:0]  a_st;
    logic [2:0]  b_succ, b_lazy, b_fail, b_idx, b_ffi, b_ld;
    logic        b_ffv, b_lv, b_ovf;
    logic [1:0]  b_st;

    always #5 clk = ~clk;

    sva_result_monitor ua (
        .sys_clk(clk), .sys_rst_n(rst_n), .start(start), .stop(stop),
        .res_valid(rv), .res_succ(rs), .res_lazy(rl), .res_fail(rf),
        .succ_cnt(a_succ), .lazy_cnt(a_lazy), .fail_cnt(a_fail),
        .eval_idx(a_idx), .first_fail_idx(a_ffi), .first_fail_vld(a_ffv),
        .status(a_st), .log_valid(a_lv), .log_data(a_ld),
        .log_ready(rdy), .log_ovf(a_ovf)
    );

    sva_result_monitor #(.CNT_WIDTH(3), .IDX_WIDTH(3), .LOG_DEPTH(DEPTH)) ub (
        .sys_clk(clk), .sys_rst_n(rst_n), .start(start), .stop(stop),
        .res_valid(rv), .res_succ(rs), .res_lazy(rl), .res_fail(rf),
        .succ_cnt(b_succ), .lazy_cnt(b_lazy), .fail_cnt(b_fail),
        .eval_idx(b_idx), .first_fail_idx(b_ffi), .first_fail_vld(b_ffv),
        .status(b_st), .log_valid(b_lv), .log_data(b_ld),
        .log_ready(rdy), .log_ovf(b_ovf)
    );

    typedef struct {
        int st;
        int succ;
        int lazy;
        int fail;
        int idx;
        int ffi;
        bit ffv;
        bit lv;
        int ld;
        bit ovf;
    } snap_t;

    snap_t sbq[$];
    int errors = 0;
    int checks = 0;

    // Reference model: unbounded counts, raw indices; widths applied at compare
    int m_st, m_succ, m_lazy, m_fail, m_idx, m_ffi;
    bit m_ffv, m_ovf;
    int mq[$];

    task automatic cmp(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic longint sat(input int x, input int w);
        longint mx = (64'd1 << w) - 1;
        return (x > mx) ? mx : longint'(x);
    endfunction

    function automatic longint wrp(input int x, input int w);
        return longint'(x) % (64'd1 << w);
    endfunction

    task automatic m_reset();
        m_st = 0; m_succ = 0; m_lazy = 0; m_fail = 0; m_idx = 0;
        m_ffi = 0; m_ffv = 0; m_ovf = 0;
        mq.delete();
    endtask

    task automatic m_step(input bit st, sp, v, s, l, f, r);
        bit pop = (mq.size() > 0) && r;
        if (m_st != 1 && st) begin
            m_st = 1; m_succ = 0; m_lazy = 0; m_fail = 0; m_idx = 0;
            m_ffv = 0; m_ovf = 0;
            mq.delete();
        end else begin
            if (pop) void'(mq.pop_front());
            if (m_st == 1 && v) begin
                if (s) m_succ++;
                if (l) m_lazy++;
                if (f) begin
                    m_fail++;
                    if (!m_ffv) begin m_ffi = m_idx; m_ffv = 1; end
                    if (mq.size() < DEPTH) mq.push_back(m_idx);
                    else m_ovf = 1;
                end
                m_idx++;
            end
            if (m_st == 1 && sp) m_st = (m_fail > 0) ? 3 : 2;
        end
    endtask

    task automatic cyc(input bit st, sp, v, s, l, f, r);
        snap_t e;
        @(negedge clk);
        start = st; stop = sp; rv = v; rs = s; rl = l; rf = f; rdy = r;
        m_step(st, sp, v, s, l, f, r);
        e.st = m_st; e.succ = m_succ; e.lazy = m_lazy; e.fail = m_fail;
        e.idx = m_idx; e.ffi = m_ffi; e.ffv = m_ffv; e.ovf = m_ovf;
        e.lv = (mq.size() > 0);
        e.ld = e.lv ? mq[0] : 0;
        sbq.push_back(e);
        @(posedge clk);
        #2;
        start = 0; stop = 0; rv = 0; rs = 0; rl = 0; rf = 0; rdy = 0;
    endtask

    task automatic cmp_dut(input string p, input int cw, input int iw,
                           input snap_t e, input longint st, sc, lc, fc,
                           input longint ix, fi, fv, lv, ld, ov);
        cmp({p, "_status"}, st, e.st);
        cmp({p, "_succ"}, sc, sat(e.succ, cw));
        cmp({p, "_lazy"}, lc, sat(e.lazy, cw));
        cmp({p, "_fail"}, fc, sat(e.fail, cw));
        cmp({p, "_idx"}, ix, wrp(e.idx, iw));
        cmp({p, "_ffv"}, fv, e.ffv);
        if (e.ffv) cmp({p, "_ffi"}, fi, wrp(e.ffi, iw));
        cmp({p, "_lvalid"}, lv, e.lv);
        if (e.lv) cmp({p, "_ldata"}, ld, wrp(e.ld, iw));
        cmp({p, "_ovf"}, ov, e.ovf);
    endtask

    always @(posedge clk) begin
        snap_t e;
        #1;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            cmp_dut("a", 16, 16, e, a_st, a_succ, a_lazy, a_fail,
                    a_idx, a_ffi, a_ffv, a_lv, a_ld, a_ovf);
            cmp_dut("b", 3, 3, e, b_st, b_succ, b_lazy, b_fail,
                    b_idx, b_ffi, b_ffv, b_lv, b_ld, b_ovf);
        end
    end

    task automatic chk_cleared(input string p);
        cmp({p, "_st"}, a_st, 0);
        cmp({p, "_succ"}, a_succ, 0);
        cmp({p, "_fail"}, a_fail, 0);
        cmp({p, "_idx"}, a_idx, 0);
        cmp({p, "_ffi"}, a_ffi, 0);
        cmp({p, "_ffv"}, a_ffv, 0);
        cmp({p, "_lv"}, a_lv, 0);
        cmp({p, "_ovf"}, a_ovf, 0);
        cmp({p, "_b_lazy"}, b_lazy, 0);
    endtask

    initial begin
        m_reset();
        #3;
        chk_cleared("rst0");
        #9 rst_n = 1'b1;

        // five successes then stop -> PASS
        cyc(1, 0, 0, 0, 0, 0, 0);
        repeat (5) cyc(0, 0, 1, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        cmp("s1_succ", a_succ, 5);
        cmp("s1_fail", a_fail, 0);
        cmp("s1_idx", a_idx, 5);
        cmp("s1_status", a_st, 2);

        // succ, fail, lazy, fail then stop -> FAIL, log 1 then 3
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 1, 0);
        cyc(0, 0, 1, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        cmp("s2_succ", a_succ, 1);
        cmp("s2_lazy", a_lazy, 1);
        cmp("s2_fail", a_fail, 2);
        cmp("s2_ffi", a_ffi, 1);
        cmp("s2_status", a_st, 3);
        cmp("s2_head0", a_ld, 1);
        cyc(0, 0, 0, 0, 0, 0, 1);
        cmp("s2_head1", a_ld, 3);
        cyc(0, 0, 0, 0, 0, 0, 1);
        cmp("s2_empty", a_lv, 0);
        cyc(0, 0, 0, 0, 0, 0, 1);

        // overflow: 6 fails into depth-4 log with no consumer
        cyc(1, 0, 0, 0, 0, 0, 0);
        repeat (6) cyc(0, 0, 1, 0, 0, 1, 0);
        cmp("s3_ovf", a_ovf, 1);
        for (int i = 0; i < 4; i++) begin
            cmp("s3_entry", a_ld, i);
            cyc(0, 0, 0, 0, 0, 0, 1);
        end
        cmp("s3_drained", a_lv, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);

        // full log, push with simultaneous pop -> accepted, no overflow
        cyc(1, 0, 0, 0, 0, 0, 0);
        repeat (4) cyc(0, 0, 1, 0, 0, 1, 0);
        cyc(0, 0, 1, 0, 0, 1, 1);
        cmp("s4_ovf", a_ovf, 0);
        cmp("s4_head", a_ld, 1);
        repeat (3) cyc(0, 0, 0, 0, 0, 0, 1);
        cmp("s4_last", a_ld, 4);
        cyc(0, 1, 0, 0, 0, 0, 1);

        // stop coincident with a fail strobe
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 1, 0);
        cmp("s5_fail", a_fail, 1);
        cmp("s5_status", a_st, 3);

        // nine successes: 3-bit instance saturates and wraps the index
        cyc(1, 0, 0, 0, 0, 0, 0);
        repeat (9) cyc(0, 0, 1, 1, 0, 0, 0);
        cmp("s6_b_succ", b_succ, 7);
        cmp("s6_b_idx", b_idx, 1);
        cmp("s6_a_succ", a_succ, 9);

        // asynchronous reset mid-run
        cyc(0, 0, 1, 0, 0, 1, 0);
        #1 rst_n = 1'b0;
        #1;
        chk_cleared("rst1");
        m_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (3) cyc(0, 0, 1, 1, 1, 1, 0);
        cmp("s7_idx", a_idx, 0);
        cmp("s7_status", a_st, 0);
        cyc(1, 1, 0, 0, 0, 0, 0);
        cmp("s7_startstop", a_st, 1);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            cyc(($urandom % 20) == 0, ($urandom % 15) == 0,
                $urandom % 2, $urandom % 2, $urandom % 2,
                $urandom % 2, ($urandom % 3) == 0);
        end
        cyc(0, 0, 0, 0, 0, 0, 0);

        for (int k = 0; k < 10 && sbq.size() > 0; k++) @(posedge clk);
        #3;
        if (sbq.size() > 0) cmp("drain_timeout", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sva_result_monitor.md
SVA_RESULT_MONITOR -- requirements
Module: sva_result_monitor

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 16, width of the saturating succ/fail/lazy counters.
REQ-002 SHALL have parameter IDX_WIDTH, default 16, width of the evaluation index.
REQ-003 SHALL have parameter LOG_DEPTH, default 4 (power of two, at least 2), depth of the fail-index log FIFO.
REQ-004 SHALL have port sys_clk  in  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port sys_rst_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  in  1  one-cycle pulse that clears the statistics and begins a run.
REQ-007 SHALL have port stop  in  1  one-cycle pulse that ends a run.
REQ-008 SHALL have port res_valid  in  1  one-cycle strobe; the checker finished one evaluation.
REQ-009 SHALL have port res_succ  in  1  evaluation reached SEND; sampled only when res_valid=1.
REQ-010 SHALL have port res_lazy  in  1  evaluation reached SLAZY; sampled only when res_valid=1.
REQ-011 SHALL have port res_fail  in  1  evaluation failed; sampled only when res_valid=1.
REQ-012 SHALL have port succ_cnt / lazy_cnt / fail_cnt  out  CNT_WIDTH each  result counters.
REQ-013 SHALL have port eval_idx  out  IDX_WIDTH  number of accepted evaluations.
REQ-014 SHALL have port first_fail_idx  out  IDX_WIDTH  eval_idx value at the first failure of the run.
REQ-015 SHALL have port first_fail_vld  out  1  first_fail_idx is valid.
REQ-016 SHALL have port status  out  2  state: 0=IDLE, 1=RUN, 2=PASS, 3=FAIL.
REQ-017 SHALL have port log_valid  out  1  log FIFO is not empty.
REQ-018 SHALL have port log_data  out  IDX_WIDTH  head of the log FIFO (fail index).
REQ-019 SHALL have port log_ready  in  1  consumer pops the log FIFO head.
REQ-020 SHALL have port log_ovf  out  1  sticky flag; a fail entry was dropped.

Function
REQ-021 SHALL implement an FSM: IDLE -start-> RUN; RUN -stop-> PASS if the final fail_cnt=0, else FAIL; PASS/FAIL -start-> RUN.
REQ-022 SHALL give start priority in IDLE/PASS/FAIL when start and stop coincide, and stop priority in RUN.
REQ-023 SHALL, on an accepted start, clear all counters, eval_idx, first_fail_vld, log FIFO and log_ovf in the same edge that enters RUN.
REQ-024 SHALL accept res_valid only in RUN, including the cycle stop is asserted; in other states it is ignored.
REQ-025 SHALL, per accepted strobe, increment eval_idx by 1, wrapping modulo 2^IDX_WIDTH.
REQ-026 SHALL increment succ_cnt, lazy_cnt and fail_cnt independently for each asserted flag, so multiple flags in one strobe all count.
REQ-027 SHALL saturate each counter at all-ones, with no wrap.
REQ-028 SHALL tag each strobe with the eval_idx value before its increment (first strobe = index 0).
REQ-029 SHALL, on the first accepted res_fail of a run, latch its index into first_fail_idx and set first_fail_vld; later fails do not change it.
REQ-030 SHALL, on each accepted res_fail, push its index into the log FIFO.
REQ-031 SHALL pop the FIFO when log_valid and log_ready are both 1; log_ready while empty has no effect.
REQ-032 SHALL, on a push to a full FIFO, accept the push if a pop occurs in the same cycle; otherwise drop it and set log_ovf.
REQ-033 SHALL update all outputs registered, one cycle after the strobe edge; a pushed entry is visible on log_valid/log_data in the next cycle.
REQ-034 SHALL make the FSM transition on stop use fail_cnt including a fail accepted in that same cycle.
REQ-035 SHALL ignore res_* flags when res_valid=0.

Reset
REQ-036 SHALL, while sys_rst_n=0, asynchronously force status=IDLE; all counters, eval_idx, first_fail_idx=0; first_fail_vld, log_valid, log_ovf=0; FIFO pointers=0.
REQ-037 SHALL, on reset mid-run, abandon the run and return to IDLE, requiring a new start.

Verification
REQ-038 SHALL cover: start; 5 strobes with succ only; stop -> succ_cnt=5, fail_cnt=0, eval_idx=5, status=PASS.
REQ-039 SHALL cover: start; strobes succ,fail,lazy,fail; stop -> counts 1/1/2, first_fail_idx=1, FIFO pops 1 then 3, status=FAIL.
REQ-040 SHALL cover: LOG_DEPTH=4, log_ready=0, 6 fail strobes -> 4 entries 0..3, log_ovf=1; full-FIFO push with a simultaneous pop -> accepted, log_ovf unchanged.
REQ-041 SHALL cover: stop coincident with a fail strobe -> fail counted, status=FAIL; start+stop in IDLE -> RUN.
REQ-042 SHALL cover: CNT_WIDTH=3, 9 succ strobes -> succ_cnt=7; IDX_WIDTH=3, 9 strobes -> eval_idx=1.
REQ-043 SHALL cover: sys_rst_n pulsed low mid-run, asynchronous to sys_clk -> outputs cleared immediately; strobes ignored until start.
